lte_sym_framer: RTL and testbench

- Upstream OFDM symbol framer for the LTE FFT path; feeds the FFT top's `Din_*` inputs in FFT mode.
- Takes a raw time-domain sample stream from the receive front end, strobed once per `CLK_FS_RATIO` clocks, plus a slot-sync pulse.
- Counts CP+symbol boundaries for the configured FFT size and CP type, and tags the first sample of each OFDM symbol (`Dout_h`) and of each 0.5 ms slot (`Dout_s`).
- Flywheels through missing slot syncs, re-aligns on misplaced ones and reports the misalignment.

---
 rtl/lte_sym_framer_pkg.sv | 32 +++
 rtl/lte_cp_len_lut.sv | 28 ++
 rtl/lte_sym_framer.sv | 185 ++++++++++++++++++
 tb/tb_lte_sym_framer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lte_sym_framer_pkg.sv
// Shared constants for the LTE OFDM symbol framer: FFT-size encodings,
// base cyclic-prefix lengths at 2048 points, symbols per slot, and the
// framer state type.
package lte_sym_framer_pkg;

  // FFT_num encodings
  localparam logic [1:0] FFT_2048 = 2'd0;
  localparam logic [1:0] FFT_1536 = 2'd1;
  localparam logic [1:0] FFT_1024 = 2'd2;
  localparam logic [1:0] FFT_512  = 2'd3;

  // Lengths at 2048 points; other sizes are derived by scaling
  localparam logic [11:0] N_2048        = 12'd2048;
  localparam logic [11:0] CP0_NORM_2048 = 12'd160;
  localparam logic [11:0] CP_NORM_2048  = 12'd144;
  localparam logic [11:0] CP_EXT_2048   = 12'd512;

  // Symbols per 0.5 ms slot
  localparam logic [2:0] SYMS_NORM = 3'd7;
  localparam logic [2:0] SYMS_EXT  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Index of the final symbol of a slot for the given CP type
  function automatic logic [2:0] last_sym(input logic cp_type);
    return cp_type ? (SYMS_EXT - 3'd1) : (SYMS_NORM - 3'd1);
  endfunction

endpackage

// File: rtl/lte_cp_len_lut.sv
// Combinational symbol-length table: (FFT size, CP type, symbol index)
// -> N + CP in samples. Lengths are built at 2048 points and scaled by
// shift-add (3/4 = 1/2 + 1/4, 1/2, 1/4); every base length is a multiple
// of 4 so the shifts are exact.
module lte_cp_len_lut
  import lte_sym_framer_pkg::*;
(
  input  logic [1:0]  fft_num,
  input  logic        cp_type,
  input  logic [2:0]  sym,
  output logic [11:0] sym_len
);

  logic [11:0] base_len;

  // Pick the 2048-point length, then scale it to the configured FFT size
  always_comb begin
    base_len = N_2048 + (cp_type ? CP_EXT_2048 :
                         ((sym == 3'd0) ? CP0_NORM_2048 : CP_NORM_2048));
    case (fft_num)
      FFT_1536: sym_len = (base_len >> 1) + (base_len >> 2);
      FFT_1024: sym_len = base_len >> 1;
      FFT_512:  sym_len = base_len >> 2;
      default:  sym_len = base_len;
    endcase
  end

endmodule

// File: rtl/lte_sym_framer.sv
// OFDM symbol framer for the LTE FFT path. Tags the first sample of each
// symbol (Dout_h) and slot (Dout_s), flywheels through missing slot syncs
// and re-aligns on misplaced ones (Sync_err). All outputs are registered.
// Optional feature macro: LTE_FRAMER_ERR_CNT_EN adds the 8-bit saturating
// Err_cnt output.
module lte_sym_framer
  import lte_sym_framer_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [1:0]           FFT_num,
  input  logic                 CP_type,
  input  logic [BIT_WIDTH-1:0] Din_i,
  input  logic [BIT_WIDTH-1:0] Din_q,
  input  logic                 Din_v,
  input  logic                 Slot_sync,
  output logic [BIT_WIDTH-1:0] Dout_i,
  output logic [BIT_WIDTH-1:0] Dout_q,
  output logic                 Dout_h,
  output logic                 Dout_s,
  output logic                 Dout_v,
  output logic [2:0]           Sym_idx,
  output logic                 Locked,
  output logic                 Sync_err
`ifdef LTE_FRAMER_ERR_CNT_EN
  ,
  output logic [7:0]           Err_cnt
`endif
);

  state_t state_q, state_d;
  // 12 bits so the 2560-sample extended-CP symbol fits
  logic [11:0] smp_q, smp_d;
  logic [2:0]  sym_q, sym_d;
  logic [1:0]  fft_q, fft_d;
  logic        cp_q, cp_d;
  logic [11:0] sym_len_q, sym_len_d;
  logic        locked_q, locked_d;

  logic signed [BIT_WIDTH-1:0] dout_i_q, dout_i_d;
  logic signed [BIT_WIDTH-1:0] dout_q_q, dout_q_d;
  logic        dout_h_q, dout_h_d;
  logic        dout_s_q, dout_s_d;
  logic        dout_v_q, dout_v_d;
  logic [2:0]  sym_idx_q, sym_idx_d;
  logic        sync_err_q, sync_err_d;

  logic        end_sym, end_slot, restart, flag_en;
  logic [11:0] lut_len;

  // Length of the symbol that the post-update counters point at
  lte_cp_len_lut u_cp_len_lut (
    .fft_num (fft_d),
    .cp_type (cp_d),
    .sym     (sym_d),
    .sym_len (lut_len)
  );

  // Framing FSM, counters and output flags
  always_comb begin
    state_d    = state_q;
    smp_d      = smp_q;
    sym_d      = sym_q;
    fft_d      = fft_q;
    cp_d       = cp_q;
    locked_d   = locked_q;
    sync_err_d = 1'b0;
    restart    = 1'b0;
    flag_en    = 1'b0;

    end_sym  = (smp_q == sym_len_q - 12'd1);
    end_slot = end_sym && (sym_q == last_sym(cp_q));

    if (Din_v) begin
      case (state_q)
        ST_IDLE: begin
          if (Slot_sync) begin
            state_d  = ST_RUN;
            locked_d = 1'b1;
            restart  = 1'b1;
            flag_en  = 1'b1;
          end
        end
        ST_RUN: begin
          flag_en = 1'b1;
          if (Slot_sync) begin
            // A sync is only expected on the sample following a slot end
            restart    = 1'b1;
            sync_err_d = !end_slot;
          end else if (end_slot) begin
            // Flywheel slot boundary: behaves like an expected sync
            restart = 1'b1;
          end else if (end_sym) begin
            smp_d = 12'd0;
            sym_d = sym_q + 3'd1;
          end else begin
            smp_d = smp_q + 12'd1;
          end
        end
        default: ;
      endcase

      if (restart) begin
        smp_d = 12'd0;
        sym_d = 3'd0;
        fft_d = FFT_num;
        cp_d  = CP_type;
      end
    end

    // Flags use the post-resync count so a resync sample is always tagged
    dout_h_d  = flag_en && (smp_d == 12'd0);
    dout_s_d  = dout_h_d && (sym_d == 3'd0);
    sym_len_d = dout_h_d ? lut_len : sym_len_q;
    sym_idx_d = sym_d;
    dout_v_d  = Din_v;
    dout_i_d  = Din_i;
    dout_q_d  = Din_q;
  end

  // State, counter and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      smp_q      <= 12'd0;
      sym_q      <= 3'd0;
      fft_q      <= FFT_2048;
      cp_q       <= 1'b0;
      sym_len_q  <= 12'd0;
      locked_q   <= 1'b0;
      dout_i_q   <= '0;
      dout_q_q   <= '0;
      dout_h_q   <= 1'b0;
      dout_s_q   <= 1'b0;
      dout_v_q   <= 1'b0;
      sym_idx_q  <= 3'd0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      smp_q      <= smp_d;
      sym_q      <= sym_d;
      fft_q      <= fft_d;
      cp_q       <= cp_d;
      sym_len_q  <= sym_len_d;
      locked_q   <= locked_d;
      dout_i_q   <= dout_i_d;
      dout_q_q   <= dout_q_d;
      dout_h_q   <= dout_h_d;
      dout_s_q   <= dout_s_d;
      dout_v_q   <= dout_v_d;
      sym_idx_q  <= sym_idx_d;
      sync_err_q <= sync_err_d;
    end
  end

`ifdef LTE_FRAMER_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of misplaced syncs
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sync_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register, cleared only by reset
  always_ff @(posedge Clk) begin
    if (Reset) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign Err_cnt = err_cnt_q;
`endif

  assign Dout_i   = dout_i_q;
  assign Dout_q   = dout_q_q;
  assign Dout_h   = dout_h_q;
  assign Dout_s   = dout_s_q;
  assign Dout_v   = dout_v_q;
  assign Sym_idx  = sym_idx_q;
  assign Locked   = locked_q;
  assign Sync_err = sync_err_q;

endmodule

// File: tb/tb_lte_sym_framer.sv
// Self-checking bench for lte_sym_framer: a directed vector table for the
// reset/lock/resync basics, then long sequences checked against a
// slot-offset reference built from hand-computed symbol lengths.
// Covers LTE_FRAMER_ERR_CNT_EN when that macro is defined.
module tb_lte_sym_framer;

  localparam int BW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [1:0]    FFT_num;
  logic          CP_type;
  logic [BW-1:0] Din_i, Din_q;
  logic          Din_v, Slot_sync;
  logic [BW-1:0] Dout_i, Dout_q;
  logic          Dout_h, Dout_s, Dout_v;
  logic [2:0]    Sym_idx;
  logic          Locked, Sync_err;
`ifdef LTE_FRAMER_ERR_CNT_EN
  logic [7:0]    Err_cnt;
`endif

  always #5 Clk = ~Clk;

  lte_sym_framer #(.BIT_WIDTH(BW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .FFT_num   (FFT_num),
    .CP_type   (CP_type),
    .Din_i     (Din_i),
    .Din_q     (Din_q),
    .Din_v     (Din_v),
    .Slot_sync (Slot_sync),
    .Dout_i    (Dout_i),
    .Dout_q    (Dout_q),
    .Dout_h    (Dout_h),
    .Dout_s    (Dout_s),
    .Dout_v    (Dout_v),
    .Sym_idx   (Sym_idx),
    .Locked    (Locked),
    .Sync_err  (Sync_err)
`ifdef LTE_FRAMER_ERR_CNT_EN
    ,
    .Err_cnt   (Err_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: position of the next sample within its slot
  bit         m_locked;
  int         m_off;
  logic [1:0] m_fft;
  logic       m_cp;
  int         m_sym;
  int         m_errcnt;

  // Observed flag counts per sequence
  int cnt_h, cnt_s, cnt_err;
  int cyc;

  // Hand-computed N+CP table
  function automatic int sym_len(input logic [1:0] f, input logic c, input int s);
    if (c) begin
      case (f)
        2'd0:    return 2560;
        2'd1:    return 1920;
        2'd2:    return 1280;
        default: return 640;
      endcase
    end else begin
      case (f)
        2'd0:    return (s == 0) ? 2208 : 2192;
        2'd1:    return (s == 0) ? 1656 : 1644;
        2'd2:    return (s == 0) ? 1104 : 1096;
        default: return (s == 0) ? 552 : 548;
      endcase
    end
  endfunction

  function automatic int n_syms(input logic c);
    return c ? 6 : 7;
  endfunction

  function automatic int slot_len(input logic [1:0] f, input logic c);
    case (f)
      2'd0:    return 15360;
      2'd1:    return 11520;
      2'd2:    return 7680;
      default: return 3840;
    endcase
  endfunction

  task automatic check_out(input string name, input logic ev, input logic eh,
                           input logic es, input logic [2:0] esym,
                           input logic elock, input logic eerr,
                           input logic [BW-1:0] ei, input logic [BW-1:0] eq);
    logic [7:0] got, exp;
    got = {Dout_v, Dout_h, Dout_s, Sym_idx, Locked, Sync_err};
    exp = {ev, eh, es, esym, elock, eerr};
    n_tests++;
    if (got !== exp || Dout_i !== ei || Dout_q !== eq) begin
      n_fail++;
      $display("FAIL %s: got v,h,s,sym,lock,err=%b i=%h q=%h, expected %b i=%h q=%h",
               name, got, Dout_i, Dout_q, exp, ei, eq);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock: drive inputs, advance reference, sample #1 after the edge
  task automatic cycle(input logic v, input logic sync, input logic rst, input string tag);
    logic eh, es, eerr, ev;
    logic [BW-1:0] ei, eq;
    int acc;
    eh = 1'b0; es = 1'b0; eerr = 1'b0; acc = 0;
    Reset = rst; Din_v = v; Slot_sync = sync;
    Din_i = 16'($urandom); Din_q = 16'($urandom);
    ei = rst ? '0 : Din_i;
    eq = rst ? '0 : Din_q;
    ev = v & !rst;
    if (rst) begin
      m_locked = 1'b0; m_off = 0; m_sym = 0; m_errcnt = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (sync) begin
          m_locked = 1'b1; m_off = 0; m_fft = FFT_num; m_cp = CP_type;
        end
      end else if (sync) begin
        eerr = (m_off != 0);
        m_off = 0; m_fft = FFT_num; m_cp = CP_type;
      end
      if (m_locked) begin
        for (int k = 0; k < n_syms(m_cp); k++) begin
          if (m_off == acc) eh = 1'b1;
          if (m_off >= acc) m_sym = k;
          acc += sym_len(m_fft, m_cp, k);
        end
        es = (m_off == 0);
        m_off++;
        if (m_off == slot_len(m_fft, m_cp)) begin
          m_off = 0; m_fft = FFT_num; m_cp = CP_type;
        end
      end else begin
        m_sym = 0;
      end
      if (eerr && m_errcnt < 255) m_errcnt++;
    end
    @(posedge Clk); #1;
    check_out($sformatf("%s@%0d", tag, cyc), ev, eh, es, 3'(m_sym), m_locked, eerr, ei, eq);
`ifdef LTE_FRAMER_ERR_CNT_EN
    check_int($sformatf("%s_err_cnt@%0d", tag, cyc), int'(Err_cnt), m_errcnt);
`endif
    if (Dout_h)   cnt_h++;
    if (Dout_s)   cnt_s++;
    if (Sync_err) cnt_err++;
    cyc++;
  endtask

  task automatic clear_counts();
    cnt_h = 0; cnt_s = 0; cnt_err = 0;
  endtask

  typedef struct {
    logic          rst, v, sync;
    logic [1:0]    fft;
    logic          cp;
    logic [BW-1:0] din;
    logic          eh, es, elock, eerr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngap;
    Reset = 1'b1; Din_v = 1'b0; Slot_sync = 1'b0; FFT_num = 2'd0; CP_type = 1'b0;
    Din_i = '0; Din_q = '0; cyc = 0;
    m_locked = 1'b0; m_off = 0; m_sym = 0; m_errcnt = 0; m_fft = 2'd0; m_cp = 1'b0;
    clear_counts();

    //                 rst   v     sync  fft   cp    din       eh    es    lock  err
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0}; // reset state
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0}; // idle strobe
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 16'h0202, 1'b0, 1'b0, 1'b0, 1'b0}; // gap
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 16'h0303, 1'b1, 1'b1, 1'b1, 1'b0}; // lock
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 16'h0404, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 16'h0505, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 16'h0606, 1'b1, 1'b1, 1'b1, 1'b1}; // misplaced
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 16'h0707, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 16'h0808, 1'b0, 1'b0, 1'b0, 1'b0}; // reset
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 16'h0909, 1'b1, 1'b1, 1'b1, 1'b0}; // relock, no err
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 16'h0A0A, 1'b1, 1'b1, 1'b1, 1'b1}; // misplaced
    tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0B0B, 1'b0, 1'b0, 1'b1, 1'b0}; // sync w/o strobe

    @(posedge Clk); #1;
    for (int i = 0; i < 12; i++) begin
      Reset = tbl[i].rst; Din_v = tbl[i].v; Slot_sync = tbl[i].sync;
      FFT_num = tbl[i].fft; CP_type = tbl[i].cp;
      Din_i = tbl[i].din; Din_q = ~tbl[i].din;
      @(posedge Clk); #1;
      check_out($sformatf("vec%0d", i), tbl[i].v & !tbl[i].rst, tbl[i].eh, tbl[i].es, 3'd0,
                tbl[i].elock, tbl[i].eerr,
                tbl[i].rst ? 16'h0000 : tbl[i].din, tbl[i].rst ? 16'h0000 : ~tbl[i].din);
    end

    // Lock at 2048 normal, FFT_num switches to 512 mid-slot at strobe 5000
    FFT_num = 2'd0; CP_type = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, "lock_rst");
    clear_counts();
    cycle(1'b1, 1'b1, 1'b0, "lock");
    for (int s = 1; s < 19210; s++) begin
      if (s == 5000) FFT_num = 2'd3;
      cycle(1'b1, 1'b0, 1'b0, "lock_cfg");
    end
    check_int("lock_cfg_dout_s_count", cnt_s, 3);
    check_int("lock_cfg_dout_h_count", cnt_h, 15);
    check_int("lock_cfg_sync_err_count", cnt_err, 0);

    // Flywheel at 1024 extended
    FFT_num = 2'd2; CP_type = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, "fly_rst");
    clear_counts();
    cycle(1'b1, 1'b1, 1'b0, "fly");
    for (int s = 1; s < 23050; s++) cycle(1'b1, 1'b0, 1'b0, "fly");
    check_int("fly_dout_s_count", cnt_s, 4);
    check_int("fly_dout_h_count", cnt_h, 19);
    check_int("fly_sync_err_count", cnt_err, 0);

    // Misplaced sync at 512 normal
    FFT_num = 2'd3; CP_type = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, "mis_rst");
    clear_counts();
    for (int s = 0; s < 5000; s++) cycle(1'b1, (s == 0 || s == 1000), 1'b0, "mis");
    check_int("mis_dout_s_count", cnt_s, 3);
    check_int("mis_dout_h_count", cnt_h, 10);
    check_int("mis_sync_err_count", cnt_err, 1);

    // Reset mid-slot, then realign at 512 with irregular strobe gaps
    FFT_num = 2'd0; CP_type = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, "rst_pre");
    for (int s = 0; s < 7000; s++) cycle(1'b1, (s == 0), 1'b0, "rst_run");
    cycle(1'b0, 1'b0, 1'b1, "rst_mid");
    check_int("rst_mid_locked", int'(Locked), 0);
    FFT_num = 2'd3;
    clear_counts();
    for (int s = 0; s < 3; s++) begin
      cycle(1'b1, 1'b0, 1'b0, "rst_idle");
      cycle(1'b0, 1'b0, 1'b0, "rst_idle_gap");
    end
    for (int s = 0; s < 2000; s++) begin
      cycle(1'b1, (s == 0), 1'b0, "gaps");
      ngap = $urandom_range(1, 7);
      for (int g = 0; g < ngap; g++) cycle(1'b0, 1'b0, 1'b0, "gaps_idle");
    end
    check_int("gaps_dout_s_count", cnt_s, 1);
    check_int("gaps_dout_h_count", cnt_h, 4);
    check_int("gaps_sync_err_count", cnt_err, 0);

`ifdef LTE_FRAMER_ERR_CNT_EN
    // 300 misplaced syncs saturate the counter
    cycle(1'b0, 1'b0, 1'b1, "sat_rst");
    cycle(1'b1, 1'b1, 1'b0, "sat");
    for (int n = 0; n < 300; n++) begin
      for (int s = 0; s < 5; s++) cycle(1'b1, 1'b0, 1'b0, "sat");
      cycle(1'b1, 1'b1, 1'b0, "sat_sync");
    end
    check_int("sat_err_cnt", int'(Err_cnt), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
